// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command loader.
// Opcode encodings match the 4-bit ALU's ctrl input.
package alu_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int CTRL_W_DEF = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    S_OP    = 2'd0,
    S_A     = 2'd1,
    S_B     = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  // Opcodes that take only operand a.
  function automatic logic is_unary(input logic [2:0] op);
    return (op == OP_NOT);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, counter debounce and rising-edge pulse for one button.
// Pulse appears DEB_CYCLES+3 cycles after a clean raw rising edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  // Synchronise, debounce, and pulse on the accepted rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= {CNT_W{1'b0}};
      pulse    <= 1'b0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      pulse    <= stable & ~stable_d;
      if (sync2 == stable) begin
        cnt <= {CNT_W{1'b0}};
      end else if (cnt == CNT_MAX) begin
        stable <= ~stable;
        cnt    <= {CNT_W{1'b0}};
      end else begin
        cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/alu_cmd_loader.sv
// Captures ctrl, a, b from switches on debounced enter presses and issues them with valid/ready.
// Optional macro ALU_CMD_UNARY_SKIP_EN: NOT commands skip operand b entry.
module alu_cmd_loader
  import alu_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CTRL_W     = CTRL_W_DEF,
  parameter int DEB_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_enter,
  input  logic              btn_clr,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        stage
);

  state_t state;
  logic   enter_pulse;
  logic   clr_pulse;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_enter (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_enter),
    .pulse (enter_pulse)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_clr),
    .pulse (clr_pulse)
  );

  assign stage = state;

  // Command sequencer; clear takes priority over enter and over a pending transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_OP;
      out_a     <= {DATA_W{1'b0}};
      out_b     <= {DATA_W{1'b0}};
      out_ctrl  <= {CTRL_W{1'b0}};
      out_valid <= 1'b0;
    end else if (clr_pulse) begin
      state     <= S_OP;
      out_a     <= {DATA_W{1'b0}};
      out_b     <= {DATA_W{1'b0}};
      out_ctrl  <= {CTRL_W{1'b0}};
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_OP: begin
          if (enter_pulse) begin
            out_ctrl <= sw[CTRL_W-1:0];
            state    <= S_A;
          end
        end
        S_A: begin
          if (enter_pulse) begin
            out_a <= sw;
`ifdef ALU_CMD_UNARY_SKIP_EN
            if (is_unary(3'(out_ctrl))) begin
              out_b     <= {DATA_W{1'b0}};
              out_valid <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              state <= S_B;
            end
`else
            state <= S_B;
`endif
          end
        end
        S_B: begin
          if (enter_pulse) begin
            out_b     <= sw;
            out_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Operands stay frozen; only a completed handshake leaves this state.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_OP;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= S_OP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_loader.sv
// Directed, table-driven bench for alu_cmd_loader with DEB_CYCLES=4.
module tb_alu_cmd_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       btn_enter;
  logic       btn_clr;
  logic [3:0] out_a;
  logic [3:0] out_b;
  logic [2:0] out_ctrl;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] stage;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] sw_op;
    logic [3:0] sw_a;
    logic [3:0] sw_b;
    logic [2:0] exp_ctrl;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
  } vec_t;

  vec_t vecs [4];

  alu_cmd_loader #(.DATA_W(4), .CTRL_W(3), .DEB_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .btn_enter (btn_enter),
    .btn_clr   (btn_clr),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_ctrl  (out_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .stage     (stage)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press_enter(input logic [3:0] val);
    sw = val;
    btn_enter = 1'b1;
    repeat (10) tick();
    btn_enter = 1'b0;
    repeat (10) tick();
  endtask

  task automatic press_clr();
    btn_clr = 1'b1;
    repeat (10) tick();
    btn_clr = 1'b0;
    repeat (10) tick();
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'b0000, 4'h5, 4'h3, 3'b000, 4'h5, 4'h3};
    vecs[1] = '{4'b1101, 4'hF, 4'h0, 3'b101, 4'hF, 4'h0};
    vecs[2] = '{4'b0111, 4'hA, 4'h6, 3'b111, 4'hA, 4'h6};
    vecs[3] = '{4'b0011, 4'h0, 4'hF, 3'b011, 4'h0, 4'hF};

    // Reset with both buttons held high.
    rst_n = 1'b0; sw = 4'h0; btn_enter = 1'b1; btn_clr = 1'b1; out_ready = 1'b0;
    repeat (2) tick();
    check("rst_a", 32'(out_a), 32'h0);
    check("rst_b", 32'(out_b), 32'h0);
    check("rst_ctrl", 32'(out_ctrl), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_stage", 32'(stage), 32'h0);

    // Enter still high after reset: pulse lands on the 7th edge, FSM moves on the 8th.
    btn_clr = 1'b0;
    rst_n = 1'b1;
    repeat (7) tick();
    check("lat_stage_early", 32'(stage), 32'h0);
    tick();
    check("lat_stage_taken", 32'(stage), 32'h1);
    btn_enter = 1'b0;
    repeat (10) tick();

    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Full sequences from the table, back to back.
    for (int i = 0; i < 4; i++) begin
      press_enter(vecs[i].sw_op);
      press_enter(vecs[i].sw_a);
      press_enter(vecs[i].sw_b);
      check($sformatf("v%0d_ctrl", i), 32'(out_ctrl), 32'(vecs[i].exp_ctrl));
      check($sformatf("v%0d_a", i), 32'(out_a), 32'(vecs[i].exp_a));
      check($sformatf("v%0d_b", i), 32'(out_b), 32'(vecs[i].exp_b));
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'h1);
      check($sformatf("v%0d_stage", i), 32'(stage), 32'h3);
      accept();
      check($sformatf("v%0d_valid_after", i), 32'(out_valid), 32'h0);
      check($sformatf("v%0d_stage_after", i), 32'(stage), 32'h0);
      check($sformatf("v%0d_a_kept", i), 32'(out_a), 32'(vecs[i].exp_a));
      check($sformatf("v%0d_b_kept", i), 32'(out_b), 32'(vecs[i].exp_b));
    end

    // Bouncy press in S_OP, with out_ready high (ignored outside S_ISSUE).
    out_ready = 1'b1;
    sw = 4'b0001;
    btn_enter = 1'b1; tick();
    btn_enter = 1'b0; tick();
    btn_enter = 1'b1; tick();
    repeat (10) tick();
    btn_enter = 1'b0;
    repeat (10) tick();
    out_ready = 1'b0;
    check("bounce_stage", 32'(stage), 32'h1);
    check("bounce_ctrl", 32'(out_ctrl), 32'h1);
    check("bounce_valid", 32'(out_valid), 32'h0);

    // Backpressure in S_ISSUE: extra enters and waiting change nothing.
    press_enter(4'h7);
    press_enter(4'h2);
    repeat (30) tick();
    press_enter(4'hE);
    press_enter(4'hB);
    check("bp_valid", 32'(out_valid), 32'h1);
    check("bp_stage", 32'(stage), 32'h3);
    check("bp_a", 32'(out_a), 32'h7);
    check("bp_b", 32'(out_b), 32'h2);
    check("bp_ctrl", 32'(out_ctrl), 32'h1);
    accept();
    check("bp_done", 32'(out_valid), 32'h0);

    // Clear in S_B.
    press_enter(4'h3);
    press_enter(4'h9);
    check("clr_pre_stage", 32'(stage), 32'h2);
    check("clr_pre_a", 32'(out_a), 32'h9);
    press_clr();
    check("clr_stage", 32'(stage), 32'h0);
    check("clr_a", 32'(out_a), 32'h0);
    check("clr_ctrl", 32'(out_ctrl), 32'h0);
    check("clr_b", 32'(out_b), 32'h0);

    // Clear and enter together in S_A: clear wins.
    press_enter(4'h5);
    check("both_pre_stage", 32'(stage), 32'h1);
    check("both_pre_ctrl", 32'(out_ctrl), 32'h5);
    sw = 4'hC;
    btn_enter = 1'b1; btn_clr = 1'b1;
    repeat (10) tick();
    btn_enter = 1'b0; btn_clr = 1'b0;
    repeat (10) tick();
    check("both_stage", 32'(stage), 32'h0);
    check("both_ctrl", 32'(out_ctrl), 32'h0);
    check("both_a", 32'(out_a), 32'h0);

    // Reset mid-sequence discards progress.
    press_enter(4'h6);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("midrst_stage", 32'(stage), 32'h0);
    check("midrst_ctrl", 32'(out_ctrl), 32'h0);

    // Leave a nonzero b behind, then enter a NOT command.
    press_enter(4'h0);
    press_enter(4'h1);
    press_enter(4'h4);
    accept();
    press_enter(4'b0010);
    press_enter(4'b0110);
    check("not_a", 32'(out_a), 32'h6);
    check("not_ctrl", 32'(out_ctrl), 32'h2);
`ifdef ALU_CMD_UNARY_SKIP_EN
    check("not_stage", 32'(stage), 32'h3);
    check("not_b", 32'(out_b), 32'h0);
    check("not_valid", 32'(out_valid), 32'h1);
`else
    check("not_stage", 32'(stage), 32'h2);
    check("not_b", 32'(out_b), 32'h4);
    check("not_valid", 32'(out_valid), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
